// File: rtl/gb_video_pkg.sv
// Shared constants, types and address helper for the Game Boy frame scaler.
// Both the write FSM and the read pipeline use the same address mapping.
package gb_video_pkg;

  localparam int GB_WIDTH  = 160;
  localparam int GB_HEIGHT = 144;
  localparam int GB_PIXELS = GB_WIDTH * GB_HEIGHT;
  localparam int RAM_DEPTH = 2 * GB_PIXELS;
  localparam int ADDR_W    = 16;

  localparam logic [7:0] GX_LAST = 8'(GB_WIDTH - 1);
  localparam logic [7:0] GY_LAST = 8'(GB_HEIGHT - 1);

  typedef logic [1:0] gb_shade_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITING,
    DONE
  } wr_state_t;

  // Flat RAM address: the bank selects the upper or lower 23040 entries.
  function automatic logic [ADDR_W-1:0] gb_addr(input logic       bank,
                                                input logic [7:0] gy,
                                                input logic [7:0] gx);
    logic [ADDR_W-1:0] base;
    base = bank ? ADDR_W'(GB_PIXELS) : '0;
    return base + ADDR_W'(gy) * ADDR_W'(GB_WIDTH) + ADDR_W'(gx);
  endfunction

endpackage

// File: rtl/gb_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Holds both display banks back to back.
module gb_frame_ram
  import gb_video_pkg::*;
(
  input  logic              clk_pixel,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  gb_shade_t         i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output gb_shade_t         o_rdata
);

  gb_shade_t r_mem [RAM_DEPTH];
  gb_shade_t r_rdata;

  // NOTE: no reset on the array or read register, so the tools can map it onto block RAM.
  always_ff @(posedge clk_pixel) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gb_frame_scaler.sv
// Double-buffered Game Boy LCD capture with integer upscaling onto the HDMI
// scan; banks swap only at HDMI frame start so a shown frame never tears.
module gb_frame_scaler
  import gb_video_pkg::*;
#(
  parameter int          SCALE      = 3,
  parameter int          X_START    = 80,
  parameter int          Y_START    = 24,
  parameter logic [23:0] SHADE0     = 24'hE0F8D0,
  parameter logic [23:0] SHADE1     = 24'h88C070,
  parameter logic [23:0] SHADE2     = 24'h346856,
  parameter logic [23:0] SHADE3     = 24'h081820,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        lcd_valid,
  input  logic [1:0]  lcd_pixel,
  input  logic        lcd_frame_start,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  output logic [23:0] rgb,
  output logic        frame_dropped
);

  localparam int              PH_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(SCALE - 1);
  localparam logic [9:0]      X_LO   = 10'(X_START);
  localparam logic [9:0]      X_HI   = 10'(X_START + SCALE * GB_WIDTH);
  localparam logic [9:0]      Y_LO   = 10'(Y_START);
  localparam logic [9:0]      Y_HI   = 10'(Y_START + SCALE * GB_HEIGHT);

  // Write side state
  wr_state_t r_state;
  logic      r_disp_bank;
  logic [7:0] r_wx, r_wy;
  logic      r_frame_dropped;

  logic              w_start, w_swap, w_wr_bank;
  logic              w_we, w_at_origin, w_drop, w_last;
  logic [7:0]        w_wx, w_wy;
  logic [ADDR_W-1:0] w_waddr;

  // Read side state
  logic [7:0]        r_gx, r_gy;
  logic [PH_W-1:0]   r_px, r_py;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_win0, r_win1;
  logic [23:0]       r_rgb;

  logic              w_x_in, w_y_in;
  logic [7:0]        w_gx_cur;
  logic [PH_W-1:0]   w_px_cur;
  gb_shade_t         w_rdata;
  logic [23:0]       w_palette;

  assign w_start = lcd_valid & lcd_frame_start;
  assign w_swap  = (cx == '0) && (cy == '0) && (r_state == DONE);
  // A swap in this cycle flips the bank, so a coincident start pixel must go
  // to the bank that is about to stop being displayed.
  assign w_wr_bank = w_swap ? r_disp_bank : ~r_disp_bank;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_we        = 1'b0;
    w_at_origin = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_we        = 1'b1;
          w_at_origin = 1'b1;
        end
      end
      WRITING: begin
        if (lcd_valid) begin
          w_we        = 1'b1;
          w_at_origin = lcd_frame_start;
        end
      end
      DONE: begin
        if (w_start) begin
          w_we        = 1'b1;
          w_at_origin = 1'b1;
          w_drop      = ~w_swap;
        end
      end
      default: ;
    endcase
  end

  assign w_wx    = w_at_origin ? 8'd0 : r_wx;
  assign w_wy    = w_at_origin ? 8'd0 : r_wy;
  assign w_last  = (w_wx == GX_LAST) && (w_wy == GY_LAST);
  assign w_waddr = gb_addr(w_wr_bank, w_wy, w_wx);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_disp_bank     <= 1'b0;
      r_wx            <= 8'd0;
      r_wy            <= 8'd0;
      r_frame_dropped <= 1'b0;
    end else begin
      r_frame_dropped <= w_drop;
      if (w_swap) begin
        r_disp_bank <= ~r_disp_bank;
      end
      if (w_we) begin
        if (w_last) begin
          r_state <= DONE;
          r_wx    <= 8'd0;
          r_wy    <= 8'd0;
        end else begin
          r_state <= WRITING;
          if (w_wx == GX_LAST) begin
            r_wx <= 8'd0;
            r_wy <= w_wy + 8'd1;
          end else begin
            r_wx <= w_wx + 8'd1;
            r_wy <= w_wy;
          end
        end
      end else if (w_swap) begin
        r_state <= IDLE;
      end
    end
  end

  gb_frame_ram u_ram (
    .clk_pixel (clk_pixel),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (lcd_pixel),
    .i_raddr   (r_raddr),
    .o_rdata   (w_rdata)
  );

  assign w_x_in = (cx >= X_LO) && (cx < X_HI);
  assign w_y_in = (cy >= Y_LO) && (cy < Y_HI);

  // The first window column must already address gx=0, so the clear is
  // applied combinationally as well as to the registers.
  assign w_gx_cur = (cx == X_LO) ? 8'd0 : r_gx;
  assign w_px_cur = (cx == X_LO) ? '0 : r_px;

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_gx    <= 8'd0;
      r_px    <= '0;
      r_gy    <= 8'd0;
      r_py    <= '0;
      r_raddr <= '0;
      r_win0  <= 1'b0;
      r_win1  <= 1'b0;
    end else begin
      if (w_x_in) begin
        if (w_px_cur == PH_MAX) begin
          r_px <= '0;
          r_gx <= w_gx_cur + 8'd1;
        end else begin
          r_px <= w_px_cur + PH_W'(1);
          r_gx <= w_gx_cur;
        end
      end
      if (cx == '0) begin
        if (cy == Y_LO) begin
          r_gy <= 8'd0;
          r_py <= '0;
        end else if ((cy > Y_LO) && (cy < Y_HI)) begin
          if (r_py == PH_MAX) begin
            r_py <= '0;
            r_gy <= r_gy + 8'd1;
          end else begin
            r_py <= r_py + PH_W'(1);
          end
        end
      end
      if (w_x_in && w_y_in) begin
        r_raddr <= gb_addr(r_disp_bank, r_gy, w_gx_cur);
      end
      r_win0 <= w_x_in && w_y_in;
      r_win1 <= r_win0;
    end
  end

  always_comb begin
    w_palette = SHADE0;
    unique case (w_rdata)
      2'd0:    w_palette = SHADE0;
      2'd1:    w_palette = SHADE1;
      2'd2:    w_palette = SHADE2;
      2'd3:    w_palette = SHADE3;
      default: w_palette = SHADE0;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_rgb <= BORDER_RGB;
    end else begin
      r_rgb <= r_win1 ? w_palette : BORDER_RGB;
    end
  end

  assign rgb           = r_rgb;
  assign frame_dropped = r_frame_dropped;

endmodule

// File: tb/tb_gb_frame_scaler.sv
// Directed bench for gb_frame_scaler: frame capture, drop, coincident swap,
// scaled window edges and mid-frame reset, checked against hand-computed colours.
module tb_gb_frame_scaler;

  localparam logic [23:0] SH0    = 24'hE0F8D0;
  localparam logic [23:0] SH1    = 24'h88C070;
  localparam logic [23:0] SH3    = 24'h081820;
  localparam logic [23:0] BORDER = 24'h000000;
  localparam int          NV     = 18;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        lcd_valid;
  logic [1:0]  lcd_pixel;
  logic        lcd_frame_start;
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [23:0] rgb;
  logic        frame_dropped;

  typedef struct {
    int          phase;
    int          cy;
    int          cx;
    logic [23:0] exp;
  } vec_t;

  vec_t vtab [NV];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   drop_cnt  = 0;
  int   hits      = 0;
  int   h_cx [3]  = '{-1, -1, -1};
  int   h_cy [3]  = '{-1, -1, -1};

  always #5 clk_pixel = ~clk_pixel;

  gb_frame_scaler dut (
    .clk_pixel       (clk_pixel),
    .reset_n         (reset_n),
    .lcd_valid       (lcd_valid),
    .lcd_pixel       (lcd_pixel),
    .lcd_frame_start (lcd_frame_start),
    .cx              (cx),
    .cy              (cy),
    .rgb             (rgb),
    .frame_dropped   (frame_dropped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: remember the scan position sampled at this edge, then look
  // just after it. rgb after edge k belongs to the position sampled at k-2.
  task automatic tick();
    h_cx[2] = h_cx[1]; h_cx[1] = h_cx[0]; h_cx[0] = int'(cx);
    h_cy[2] = h_cy[1]; h_cy[1] = h_cy[0]; h_cy[0] = int'(cy);
    @(posedge clk_pixel);
    #1;
    if (frame_dropped === 1'b1) drop_cnt++;
  endtask

  task automatic put_pixel(input bit start, input logic [1:0] shade);
    lcd_valid       = 1'b1;
    lcd_frame_start = start;
    lcd_pixel       = shade;
    tick();
    lcd_valid       = 1'b0;
    lcd_frame_start = 1'b0;
  endtask

  // kind 0: all shade 2; kind 1: all shade 3 except (159,143) = shade 1
  task automatic write_frame(input int kind);
    for (int y = 0; y < 144; y++) begin
      for (int x = 0; x < 160; x++) begin
        if (kind == 0) put_pixel(x == 0 && y == 0, 2'd2);
        else           put_pixel(x == 0 && y == 0, (x == 159 && y == 143) ? 2'd1 : 2'd3);
      end
    end
  endtask

  function automatic bit line_probed(input int phase, input int y);
    bit found = 1'b0;
    for (int i = 0; i < NV; i++)
      if (vtab[i].phase == phase && vtab[i].cy == y) found = 1'b1;
    return found;
  endfunction

  function automatic int phase_count(input int phase);
    int n = 0;
    for (int i = 0; i < NV; i++)
      if (vtab[i].phase == phase) n++;
    return n;
  endfunction

  task automatic probe(input int phase);
    for (int i = 0; i < NV; i++) begin
      if (vtab[i].phase == phase && vtab[i].cx == h_cx[2] && vtab[i].cy == h_cy[2]) begin
        hits++;
        check($sformatf("ph%0d rgb@(%0d,%0d)", phase, vtab[i].cx, vtab[i].cy),
              32'(rgb), 32'(vtab[i].exp));
      end
    end
  endtask

  // Reduced HDMI scan: cx=0 on every line (drives the vertical counters and
  // the swap at 0,0); full cx sweeps only on lines that carry probes.
  task automatic scan(input int phase, input int last_cy, input bit with_start,
                      input logic [1:0] start_shade);
    hits = 0;
    for (int y = 0; y <= last_cy; y++) begin
      cy = 10'(y);
      cx = 10'd0;
      if (y == 0 && with_start) begin
        lcd_valid       = 1'b1;
        lcd_frame_start = 1'b1;
        lcd_pixel       = start_shade;
      end
      tick();
      lcd_valid       = 1'b0;
      lcd_frame_start = 1'b0;
      probe(phase);
      if (line_probed(phase, y)) begin
        for (int x = 1; x <= 562; x++) begin
          cx = 10'(x);
          tick();
          probe(phase);
        end
      end
    end
    cx = 10'd1;
    cy = 10'd500;
    for (int k = 0; k < 2; k++) begin
      tick();
      probe(phase);
    end
    check($sformatf("ph%0d probes reached", phase), 32'(hits), 32'(phase_count(phase)));
  endtask

  initial begin
    // Phase 1: shade-3 frame with (159,143)=1 displayed after the swap
    vtab[0]  = '{1,  23, 100, BORDER};
    vtab[1]  = '{1,  24,  79, BORDER};
    vtab[2]  = '{1,  24,  80, SH3};
    vtab[3]  = '{1,  24,  81, SH3};
    vtab[4]  = '{1,  24, 559, SH3};
    vtab[5]  = '{1,  24, 560, BORDER};
    vtab[6]  = '{1, 453, 556, SH3};
    vtab[7]  = '{1, 453, 557, SH1};
    vtab[8]  = '{1, 453, 559, SH1};
    vtab[9]  = '{1, 454, 558, SH1};
    vtab[10] = '{1, 455, 559, SH1};
    vtab[11] = '{1, 455, 560, BORDER};
    vtab[12] = '{1, 456, 557, BORDER};
    // Phase 2: after reset bank 0 is shown: (0,0)=0, (1..50,0)=1
    vtab[13] = '{2,  24,  79, BORDER};
    vtab[14] = '{2,  24,  80, SH0};
    vtab[15] = '{2,  24,  82, SH0};
    vtab[16] = '{2,  24,  83, SH1};
    vtab[17] = '{2,  24, 232, SH1};

    reset_n         = 1'b0;
    lcd_valid       = 1'b0;
    lcd_frame_start = 1'b0;
    lcd_pixel       = 2'd0;
    cx              = 10'd1;
    cy              = 10'd500;
    repeat (3) tick();
    check("reset rgb", 32'(rgb), 32'(BORDER));
    check("reset frame_dropped", 32'(frame_dropped), 32'd0);
    reset_n = 1'b1;
    tick();

    // First frame lands in bank 1 and completes without being shown
    write_frame(0);
    tick();
    check("no drop after first frame", 32'(drop_cnt), 32'd0);

    // Start in DONE discards the ready frame with a pulse
    put_pixel(1'b1, 2'd0);
    check("drop pulse", 32'(frame_dropped), 32'd1);
    repeat (9) put_pixel(1'b0, 2'd0);
    check("drop pulse width", 32'(drop_cnt), 32'd1);

    // Restart within WRITING: no further pulse, frame rewritten from (0,0)
    write_frame(1);
    tick();
    check("restart without pulse", 32'(drop_cnt), 32'd1);

    // Swap coincides with a new frame start carrying shade 0
    scan(1, 457, 1'b1, 2'd0);
    check("coincident swap no drop", 32'(drop_cnt), 32'd1);

    // Continue writing bank 0 while parked inside the window
    cx = 10'd80;
    cy = 10'd30;
    repeat (50) put_pixel(1'b0, 2'd1);
    check("rgb before reset", 32'(rgb), 32'(SH3));

    reset_n = 1'b0;
    tick();
    check("rgb in reset", 32'(rgb), 32'(BORDER));
    check("frame_dropped in reset", 32'(frame_dropped), 32'd0);
    reset_n = 1'b1;
    cx = 10'd1;
    cy = 10'd500;

    repeat (300) put_pixel(1'b0, 2'd3);
    check("pixels ignored after reset", 32'(drop_cnt), 32'd1);

    scan(2, 25, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
